// File: rtl/toggle_seq_arbiter_pkg.sv
// Shared definitions for the toggle-sequence arbiter: state codes and
// default sizing used by the interface and the top level.
package toggle_seq_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ARB   = 3'd1;
  localparam logic [2:0] ST_CLR   = 3'd2;
  localparam logic [2:0] ST_PRIME = 3'd3;
  localparam logic [2:0] ST_PULSE = 3'd4;
  localparam logic [2:0] ST_GAP   = 3'd5;
  localparam logic [2:0] ST_CHECK = 3'd6;
  localparam logic [2:0] ST_DONE  = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_ARB   = ST_ARB,
    S_CLR   = ST_CLR,
    S_PRIME = ST_PRIME,
    S_PULSE = ST_PULSE,
    S_GAP   = ST_GAP,
    S_CHECK = ST_CHECK,
    S_DONE  = ST_DONE
  } state_t;

  localparam int DEF_NREQ  = 4;
  localparam int DEF_CNT_W = 4;
  localparam int DEF_GAP   = 1;

endpackage

// File: rtl/toggle_seq_arbiter_if.sv
// Requester-side bundle: level requests with per-requester pulse counts,
// and the grant/status returned by the arbiter.
interface toggle_seq_arbiter_if
  import toggle_seq_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int CNT_W = DEF_CNT_W
);
  logic [NREQ-1:0]       req;
  logic [NREQ*CNT_W-1:0] cnt;
  logic [NREQ-1:0]       gnt;
  logic                  busy;
  logic                  done;
  logic                  err;

  modport master (output req, output cnt, input gnt, input busy, input done, input err);
  modport slave  (input req, input cnt, output gnt, output busy, output done, output err);
endinterface

// File: rtl/toggle_seq_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after the
// pointer, wrapping, reported both one-hot and as an index.
module rr_pick #(
  parameter int NREQ  = 4,
  parameter int IDX_W = 2
) (
  input  logic [NREQ-1:0]  i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [NREQ-1:0]  o_win,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);
  logic [IDX_W-1:0] w_cand [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_cand
      assign w_cand[gi] = (int'(i_ptr) + gi >= NREQ) ? IDX_W'(int'(i_ptr) + gi - NREQ)
                                                      : IDX_W'(int'(i_ptr) + gi);
    end
  endgenerate

  // Scan from the farthest candidate so the nearest one wins by overwrite.
  always_comb begin
    o_win = '0;
    o_idx = '0;
    o_any = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (i_req[w_cand[k]]) begin
        o_win           = '0;
        o_win[w_cand[k]] = 1'b1;
        o_idx           = w_cand[k];
        o_any           = 1'b1;
      end
    end
  end
endmodule

// File: rtl/toggle_seq_arbiter.sv
// Shares one external toggle FSM among NREQ requesters: resets it, drives
// the granted number of din pulses, then checks dout against the parity.
module toggle_seq_arbiter
  import toggle_seq_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int CNT_W = DEF_CNT_W,
  parameter int GAP   = DEF_GAP
) (
  input  logic               clk,
  input  logic               rst,
  toggle_seq_arbiter_if.slave bus,
  output logic               fsm_rst,
  output logic               fsm_din,
  input  logic               fsm_dout
);
  localparam int         IDX_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [3:0] GAP_LD = 4'((GAP > 0) ? GAP - 1 : 0);

  state_t             r_state;
  logic [NREQ-1:0]    r_gnt;
  logic [IDX_W-1:0]   r_idx;
  logic [IDX_W-1:0]   r_ptr;
  logic [CNT_W-1:0]   r_rem;
  logic [3:0]         r_gap;
  logic               r_expect;
  logic               r_busy;
  logic               r_done;
  logic               r_err;
  logic               r_fsm_rst;
  logic               r_fsm_din;

  logic [NREQ-1:0]    w_win;
  logic [IDX_W-1:0]   w_idx;
  logic               w_any;
  logic [CNT_W-1:0]   w_cnt;
  logic [CNT_W-1:0]   w_rem_dec;

  rr_pick #(.NREQ(NREQ), .IDX_W(IDX_W)) u_pick (
    .i_req (bus.req),
    .i_ptr (r_ptr),
    .o_win (w_win),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  assign w_cnt     = bus.cnt[int'(w_idx)*CNT_W +: CNT_W];
  assign w_rem_dec = r_rem - 1'b1;

  // Output registers are loaded with the decode of the state being entered.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_gnt     <= '0;
      r_idx     <= '0;
      r_ptr     <= '0;
      r_rem     <= '0;
      r_gap     <= '0;
      r_expect  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_fsm_rst <= 1'b1;
      r_fsm_din <= 1'b0;
    end else begin
      r_fsm_rst <= 1'b0;
      r_fsm_din <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (|bus.req) begin
            r_state <= S_ARB;
            r_busy  <= 1'b1;
          end
        end
        S_ARB: begin
          if (w_any) begin
            r_gnt     <= w_win;
            r_idx     <= w_idx;
            r_rem     <= w_cnt;
            r_expect  <= w_cnt[0];
            r_fsm_rst <= 1'b1;
            r_state   <= S_CLR;
          end else begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_CLR: r_state <= S_PRIME;
        S_PRIME: begin
          if (r_rem != '0) begin
            r_fsm_din <= 1'b1;
            r_state   <= S_PULSE;
          end else begin
            r_state <= S_CHECK;
          end
        end
        S_PULSE: begin
          r_rem <= w_rem_dec;
          if (GAP != 0) begin
            r_gap   <= GAP_LD;
            r_state <= S_GAP;
          end else if (w_rem_dec != '0) begin
            r_fsm_din <= 1'b1;
            r_state   <= S_PULSE;
          end else begin
            r_state <= S_CHECK;
          end
        end
        S_GAP: begin
          if (r_gap != '0) begin
            r_gap <= r_gap - 1'b1;
          end else if (r_rem != '0) begin
            r_fsm_din <= 1'b1;
            r_state   <= S_PULSE;
          end else begin
            r_state <= S_CHECK;
          end
        end
        S_CHECK: begin
          r_done  <= 1'b1;
          r_err   <= (fsm_dout != r_expect);
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_ptr   <= (int'(r_idx) == NREQ - 1) ? '0 : r_idx + 1'b1;
          r_gnt   <= '0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state   <= S_IDLE;
          r_gnt     <= '0;
          r_busy    <= 1'b0;
          r_fsm_rst <= 1'b1;
        end
      endcase
    end
  end

  assign bus.gnt  = r_gnt;
  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.err  = r_err;
  assign fsm_rst  = r_fsm_rst;
  assign fsm_din  = r_fsm_din;
endmodule

// File: tb/tb_toggle_seq_arbiter.sv
// Directed bench: two arbiters (GAP=1 and GAP=0), each driving its own
// behavioural toggle FSM, checked against hand-computed expectations.
module tb_toggle_seq_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic sel;
  logic force_lo;
  int   nvec = 0;
  int   nmis = 0;

  always #5 clk = ~clk;

  toggle_seq_arbiter_if #(.NREQ(4), .CNT_W(4)) bus1 ();
  toggle_seq_arbiter_if #(.NREQ(4), .CNT_W(4)) bus0 ();

  logic f1_rst, f1_din, f1_dout, f0_rst, f0_din, f0_dout;
  logic [1:0] f1_st, f0_st;

  toggle_seq_arbiter #(.NREQ(4), .CNT_W(4), .GAP(1)) u_dut1 (
    .clk(clk), .rst(rst), .bus(bus1),
    .fsm_rst(f1_rst), .fsm_din(f1_din), .fsm_dout(f1_dout & ~force_lo)
  );
  toggle_seq_arbiter #(.NREQ(4), .CNT_W(4), .GAP(0)) u_dut0 (
    .clk(clk), .rst(rst), .bus(bus0),
    .fsm_rst(f0_rst), .fsm_din(f0_din), .fsm_dout(f0_dout)
  );

  // Toggle FSM model: 0=idle, 1=s0, 2=s1; dout high in s1.
  always @(posedge clk) begin
    if (f1_rst) f1_st <= 2'd0;
    else if (f1_st == 2'd0) f1_st <= 2'd1;
    else if (f1_din) f1_st <= (f1_st == 2'd1) ? 2'd2 : 2'd1;
    if (f0_rst) f0_st <= 2'd0;
    else if (f0_st == 2'd0) f0_st <= 2'd1;
    else if (f0_din) f0_st <= (f0_st == 2'd1) ? 2'd2 : 2'd1;
  end
  assign f1_dout = (f1_st == 2'd2);
  assign f0_dout = (f0_st == 2'd2);

  logic [3:0] m_gnt;
  logic m_busy, m_done, m_err, m_din, m_frst, m_dout;
  assign m_gnt  = sel ? bus0.gnt  : bus1.gnt;
  assign m_busy = sel ? bus0.busy : bus1.busy;
  assign m_done = sel ? bus0.done : bus1.done;
  assign m_err  = sel ? bus0.err  : bus1.err;
  assign m_din  = sel ? f0_din    : f1_din;
  assign m_frst = sel ? f0_rst    : f1_rst;
  assign m_dout = sel ? f0_dout   : f1_dout;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Steps until done; collects pulse statistics and invariant violations.
  task automatic run_grant(input int budget, output int cyc, output int pulses,
                           output int max_run, output int min_gap, output int max_gap,
                           output logic [3:0] gnt_seen, output logic onehot_ok,
                           output logic din_ok, output logic busy_ok,
                           output logic err_v, output logic dout_v);
    int run = 0;
    int zrun = 0;
    logic seen = 1'b0;
    cyc = 0; pulses = 0; max_run = 0; min_gap = 99; max_gap = 0;
    gnt_seen = '0; onehot_ok = 1'b1; din_ok = 1'b1; busy_ok = 1'b1;
    err_v = 1'b0; dout_v = 1'b0;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (m_gnt != '0) begin
        if (!$onehot(m_gnt) || (gnt_seen != '0 && gnt_seen != m_gnt)) onehot_ok = 1'b0;
        gnt_seen = m_gnt;
      end
      if (m_din && (m_frst || m_done)) din_ok = 1'b0;
      if (!m_busy) busy_ok = 1'b0;
      if (m_din) begin
        if (seen && zrun > 0) begin
          if (zrun < min_gap) min_gap = zrun;
          if (zrun > max_gap) max_gap = zrun;
        end
        pulses++; run++; zrun = 0; seen = 1'b1;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
        if (seen) zrun++;
      end
      if (m_done) begin
        cyc = i; err_v = m_err; dout_v = m_dout;
        break;
      end
    end
  endtask

  task automatic grant(input string tag, input logic [3:0] exp_gnt, input int exp_cyc,
                       input int exp_pulses, input int exp_gap, input int exp_run,
                       input logic exp_err, input logic exp_dout, input logic drop);
    int cyc, pulses, max_run, min_gap, max_gap;
    logic [3:0] g;
    logic oh, dok, bok, e, d;
    run_grant(200, cyc, pulses, max_run, min_gap, max_gap, g, oh, dok, bok, e, d);
    check({tag, "_done_seen"}, 32'(cyc != 0), 32'd1);
    check({tag, "_gnt"}, 32'(g), 32'(exp_gnt));
    check({tag, "_latency"}, 32'(cyc), 32'(exp_cyc));
    check({tag, "_pulses"}, 32'(pulses), 32'(exp_pulses));
    if (exp_gap >= 0) begin
      check({tag, "_gap_min"}, 32'(min_gap), 32'(exp_gap));
      check({tag, "_gap_max"}, 32'(max_gap), 32'(exp_gap));
    end
    if (exp_run >= 0) check({tag, "_run"}, 32'(max_run), 32'(exp_run));
    check({tag, "_err"}, 32'(e), 32'(exp_err));
    check({tag, "_dout"}, 32'(d), 32'(exp_dout));
    check({tag, "_onehot"}, 32'(oh), 32'd1);
    check({tag, "_din_legal"}, 32'(dok), 32'd1);
    check({tag, "_busy_held"}, 32'(bok), 32'd1);
    if (drop) begin
      bus1.req = '0;
      bus0.req = '0;
    end
    tick();
    check({tag, "_done_1cyc"}, 32'(m_done), 32'd0);
    check({tag, "_gnt_clear"}, 32'(m_gnt), 32'd0);
  endtask

  initial begin
    bit got;
    rst = 1'b0; sel = 1'b0; force_lo = 1'b0;
    bus1.req = '0; bus1.cnt = '0; bus0.req = '0; bus0.cnt = '0;
    repeat (3) tick();
    check("rst_gnt", 32'(m_gnt), 32'd0);
    check("rst_busy", 32'(m_busy), 32'd0);
    check("rst_done", 32'(m_done), 32'd0);
    check("rst_err", 32'(m_err), 32'd0);
    check("rst_din", 32'(m_din), 32'd0);
    check("rst_fsm_rst", 32'(m_frst), 32'd1);
    rst = 1'b1;
    tick();
    check("idle_fsm_rst", 32'(m_frst), 32'd0);
    check("idle_busy", 32'(m_busy), 32'd0);

    bus1.cnt = 16'h0003; bus1.req = 4'b0001;
    grant("single", 4'b0001, 11, 3, 1, 1, 1'b0, 1'b1, 1'b1);
    bus1.cnt = 16'h0000; bus1.req = 4'b0001;
    grant("cnt0", 4'b0001, 5, 0, -1, 0, 1'b0, 1'b0, 1'b1);
    bus1.cnt = 16'h000F; bus1.req = 4'b0001;
    grant("cnt15", 4'b0001, 35, 15, 1, 1, 1'b0, 1'b1, 1'b1);

    force_lo = 1'b1;
    bus1.cnt = 16'h0001; bus1.req = 4'b0001;
    grant("fault", 4'b0001, 7, 1, -1, 1, 1'b1, 1'b1, 1'b1);
    force_lo = 1'b0;

    bus1.cnt = 16'h0005; bus1.req = 4'b0001;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (m_din) begin
        got = 1'b1;
        break;
      end
    end
    check("abort_reach_pulse", 32'(got), 32'd1);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("abort_gnt", 32'(m_gnt), 32'd0);
      check("abort_busy", 32'(m_busy), 32'd0);
      check("abort_done", 32'(m_done), 32'd0);
      check("abort_din", 32'(m_din), 32'd0);
      check("abort_fsm_rst", 32'(m_frst), 32'd1);
    end
    rst = 1'b1;
    grant("restart", 4'b0001, 15, 5, 1, 1, 1'b0, 1'b1, 1'b1);

    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    bus1.cnt = {4'd4, 4'd3, 4'd2, 4'd1};
    bus1.req = 4'b1111;
    grant("rr0", 4'b0001, 7, 1, -1, 1, 1'b0, 1'b1, 1'b0);
    grant("rr1", 4'b0010, 9, 2, 1, 1, 1'b0, 1'b0, 1'b0);
    grant("rr2", 4'b0100, 11, 3, 1, 1, 1'b0, 1'b1, 1'b0);
    grant("rr3", 4'b1000, 13, 4, 1, 1, 1'b0, 1'b0, 1'b0);
    grant("rr4", 4'b0001, 7, 1, -1, 1, 1'b0, 1'b1, 1'b1);

    sel = 1'b1;
    bus0.cnt = 16'h0004; bus0.req = 4'b0001;
    grant("gap0", 4'b0001, 9, 4, -1, 4, 1'b0, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
